matrix_pe_param: RTL and testbench

MATRIX_PE_PARAM -- requirements
Module: matrix_pe_param

---
 rtl/matrix_pe_param.sv | 137 +++++++++++++
 tb/tb_matrix_pe_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_pe_param.sv
// Multi-lane signed dot-product engine: consumes N neuron/weight beat pairs,
// accumulates lane products through a two-stage pipe and returns a RES_W result.
module matrix_pe_param #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int RES_W = 32,
  parameter int CNT_W = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*DW-1:0]   nram_mpe_neuron,
  input  logic                  nram_mpe_neuron_valid,
  output logic                  nram_mpe_neuron_ready,
  input  logic [LANES*DW-1:0]   wram_mpe_weight,
  input  logic                  wram_mpe_weight_valid,
  output logic                  wram_mpe_weight_ready,
  input  logic [CNT_W:0]        ib_ctl_uop,
  input  logic                  ib_ctl_uop_valid,
  output logic                  ib_ctl_uop_ready,
  output logic [RES_W-1:0]      result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_ovf,
  output logic                  busy
);

  localparam int ACC_W = 2*DW + $clog2(LANES) + CNT_W + 1;
  localparam int PW    = 2*DW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                   state, state_nxt;
  logic                     sat_mode;
  logic [CNT_W-1:0]         n_lat;
  logic [CNT_W:0]           cnt;
  logic [CNT_W:0]           tgt;
  logic                     drain_cnt;
  logic signed [PW-1:0]     prod     [LANES];
  logic signed [PW-1:0]     prod_nxt [LANES];
  logic                     prod_vld;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  lane_sum;
  logic [ACC_W-RES_W:0]     acc_hi;
  logic                     ovf_nxt;
  logic [RES_W-1:0]         result_nxt;
  logic                     uop_fire;
  logic                     pair_fire;
  logic                     last_pair;
  logic                     load_res;

  assign ib_ctl_uop_ready      = (state == IDLE);
  assign nram_mpe_neuron_ready = (state == RUN) && wram_mpe_weight_valid;
  assign wram_mpe_weight_ready = (state == RUN) && nram_mpe_neuron_valid;
  assign busy                  = (state != IDLE);
  assign res_valid             = (state == OUT);

  assign uop_fire  = ib_ctl_uop_valid && ib_ctl_uop_ready;
  assign pair_fire = (state == RUN) && nram_mpe_neuron_valid && wram_mpe_weight_valid;
  // N == 0 encodes a full 2^CNT_W beats via the extra count bit
  assign tgt       = {n_lat == '0, n_lat};
  assign last_pair = pair_fire && ((cnt + 1'b1) == tgt);
  assign load_res  = (state == DRAIN) && drain_cnt;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      prod_nxt[i] = PW'($signed(nram_mpe_neuron[i*DW +: DW])) *
                    PW'($signed(wram_mpe_weight[i*DW +: DW]));
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + ACC_W'(prod[i]);
    end
  end

  // Representable iff all bits from the RES_W sign bit upward agree
  always_comb begin
    acc_hi  = acc[ACC_W-1:RES_W-1];
    ovf_nxt = !((&acc_hi) || !(|acc_hi));
    if (sat_mode && ovf_nxt)
      result_nxt = acc[ACC_W-1] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
    else
      result_nxt = acc[RES_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (uop_fire)               state_nxt = RUN;
      RUN:   if (last_pair)              state_nxt = DRAIN;
      DRAIN: if (drain_cnt)              state_nxt = OUT;
      OUT:   if (res_valid && res_ready) state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_mode  <= 1'b0;
      n_lat     <= '0;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      result    <= '0;
      res_ovf   <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) prod[i] <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      prod_vld  <= pair_fire;
      if (pair_fire) begin
        for (int unsigned i = 0; i < LANES; i++) prod[i] <= prod_nxt[i];
      end
      if (uop_fire) begin
        sat_mode <= ib_ctl_uop[CNT_W];
        n_lat    <= ib_ctl_uop[CNT_W-1:0];
        cnt      <= '0;
        acc      <= '0;
      end else begin
        if (pair_fire) cnt <= cnt + 1'b1;
        if (prod_vld)  acc <= acc + lane_sum;
      end
      if (load_res) begin
        result  <= result_nxt;
        res_ovf <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_matrix_pe_param.sv
// Directed self-checking bench for matrix_pe_param with default parameters.
module tb_matrix_pe_param;

  localparam int LANES = 32;
  localparam int DW    = 16;
  localparam int RES_W = 32;
  localparam int CNT_W = 7;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [LANES*DW-1:0] nram_mpe_neuron;
  logic                nram_mpe_neuron_valid;
  logic                nram_mpe_neuron_ready;
  logic [LANES*DW-1:0] wram_mpe_weight;
  logic                wram_mpe_weight_valid;
  logic                wram_mpe_weight_ready;
  logic [CNT_W:0]      ib_ctl_uop;
  logic                ib_ctl_uop_valid;
  logic                ib_ctl_uop_ready;
  logic [RES_W-1:0]    result;
  logic                res_valid;
  logic                res_ready;
  logic                res_ovf;
  logic                busy;

  int checks    = 0;
  int failures  = 0;
  int pairs_mon = 0;
  int one_sided = 0;

  matrix_pe_param #(.LANES(LANES), .DW(DW), .RES_W(RES_W), .CNT_W(CNT_W)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .nram_mpe_neuron       (nram_mpe_neuron),
    .nram_mpe_neuron_valid (nram_mpe_neuron_valid),
    .nram_mpe_neuron_ready (nram_mpe_neuron_ready),
    .wram_mpe_weight       (wram_mpe_weight),
    .wram_mpe_weight_valid (wram_mpe_weight_valid),
    .wram_mpe_weight_ready (wram_mpe_weight_ready),
    .ib_ctl_uop            (ib_ctl_uop),
    .ib_ctl_uop_valid      (ib_ctl_uop_valid),
    .ib_ctl_uop_ready      (ib_ctl_uop_ready),
    .result                (result),
    .res_valid             (res_valid),
    .res_ready             (res_ready),
    .res_ovf               (res_ovf),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (nram_mpe_neuron_valid && nram_mpe_neuron_ready &&
          wram_mpe_weight_valid && wram_mpe_weight_ready) pairs_mon++;
      if ((nram_mpe_neuron_valid && nram_mpe_neuron_ready) !=
          (wram_mpe_weight_valid && wram_mpe_weight_ready)) one_sided++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_uniform(input logic [DW-1:0] n, input logic [DW-1:0] w);
    for (int i = 0; i < LANES; i++) begin
      nram_mpe_neuron[i*DW +: DW] = n;
      wram_mpe_weight[i*DW +: DW] = w;
    end
  endtask

  task automatic issue(input logic sat, input logic [CNT_W-1:0] n);
    @(negedge clk);
    check("uop_ready_idle", ib_ctl_uop_ready, 1);
    ib_ctl_uop       = {sat, n};
    ib_ctl_uop_valid = 1'b1;
    @(negedge clk);
    ib_ctl_uop_valid = 1'b0;
    check("busy_run", busy, 1);
  endtask

  task automatic feed(input int n_pairs, input bit rnd);
    int got = 0;
    int cyc = 0;
    while (got < n_pairs && cyc < 2000) begin
      @(negedge clk);
      nram_mpe_neuron_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wram_mpe_weight_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (nram_mpe_neuron_valid && nram_mpe_neuron_ready &&
          wram_mpe_weight_valid && wram_mpe_weight_ready) got++;
      cyc++;
    end
    if (got < n_pairs) check("feed_timeout", got, n_pairs);
  endtask

  // Valids stay high while draining so stray consumption would show up
  task automatic wait_result();
    int lat = 0;
    nram_mpe_neuron_valid = 1'b1;
    wram_mpe_weight_valid = 1'b1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (res_valid) break;
    end
    nram_mpe_neuron_valid = 1'b0;
    wram_mpe_weight_valid = 1'b0;
    check("res_latency", lat, 3);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_uop_ready", ib_ctl_uop_ready, 1);
    check("idle_res_valid", res_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_uniform(input string tag, input logic sat, input logic [CNT_W-1:0] n,
                             input int pairs, input logic [DW-1:0] nv, input logic [DW-1:0] wv,
                             input logic [RES_W-1:0] exp_res, input logic exp_ovf);
    int p0;
    set_uniform(nv, wv);
    p0 = pairs_mon;
    issue(sat, n);
    feed(pairs, 1'b0);
    wait_result();
    check({tag, "_result"}, result, exp_res);
    check({tag, "_ovf"}, res_ovf, exp_ovf);
    check({tag, "_pairs"}, pairs_mon - p0, pairs);
    release_res();
  endtask

  initial begin
    int p0, o0;
    rst_n = 1'b0;
    nram_mpe_neuron = '0;
    wram_mpe_weight = '0;
    nram_mpe_neuron_valid = 1'b1;
    wram_mpe_weight_valid = 1'b1;
    ib_ctl_uop = '0;
    ib_ctl_uop_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_uop_ready", ib_ctl_uop_ready, 1);
    check("rst_n_ready", nram_mpe_neuron_ready, 0);
    check("rst_w_ready", wram_mpe_weight_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_ovf", res_ovf, 0);
    rst_n = 1'b1;
    nram_mpe_neuron_valid = 1'b0;
    wram_mpe_weight_valid = 1'b0;

    run_uniform("single", 1'b0, 7'd1, 1, 16'd1, 16'd2, 32'd64, 1'b0);

    // Ramp neurons (i-16) against weight 3: per beat 3*(-16) = -48, four beats -192
    for (int i = 0; i < LANES; i++) begin
      nram_mpe_neuron[i*DW +: DW] = 16'(i - 16);
      wram_mpe_weight[i*DW +: DW] = 16'd3;
    end
    p0 = pairs_mon;
    o0 = one_sided;
    issue(1'b0, 7'd4);
    feed(4, 1'b1);
    wait_result();
    check("rand_result", result, 32'hFFFF_FF40);
    check("rand_ovf", res_ovf, 0);
    check("rand_pairs", pairs_mon - p0, 4);
    check("rand_one_sided", one_sided - o0, 0);
    release_res();

    run_uniform("sat_pos", 1'b1, 7'd0, 128, 16'h8000, 16'h8000, 32'h7FFF_FFFF, 1'b1);
    run_uniform("wrap", 1'b0, 7'd0, 128, 16'h8000, 16'h8000, 32'h0000_0000, 1'b1);
    run_uniform("sat_neg", 1'b1, 7'd0, 128, 16'h8000, 16'h7FFF, 32'h8000_0000, 1'b1);

    set_uniform(-16'sd3, 16'sd5);
    issue(1'b0, 7'd2);
    feed(2, 1'b0);
    wait_result();
    check("mixed_result", result, 32'hFFFF_FC40);
    check("mixed_ovf", res_ovf, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result", result, 32'hFFFF_FC40);
      check("hold_valid", res_valid, 1);
      check("hold_uop_ready", ib_ctl_uop_ready, 0);
    end
    release_res();

    set_uniform(16'd1, 16'd2);
    issue(1'b1, 7'd4);
    feed(2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_n_ready", nram_mpe_neuron_ready, 0);
    check("abort_w_ready", wram_mpe_weight_ready, 0);
    check("abort_result", result, 0);
    check("abort_ovf", res_ovf, 0);
    check("abort_uop_ready", ib_ctl_uop_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    nram_mpe_neuron_valid = 1'b0;
    wram_mpe_weight_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_result", res_valid, 0);

    run_uniform("after_rst", 1'b0, 7'd1, 1, 16'd1, 16'd2, 32'd64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
